// File: rtl/mem_writeback_if.sv
// rtl/mem_writeback_if.sv - execute, data-memory and register-file writeback signal bundle
interface mem_writeback_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_addr;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_dest_reg;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bus_err;
  logic        misalign_trap;

  modport master (
    input  ex_valid, ex_result, ex_addr, ex_mem_write, ex_mem_to_reg, ex_funct3, ex_dest_reg,
    input  dmem_ack, dmem_rdata,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_we, wb_rd, wb_data, bus_err, misalign_trap
  );

  modport slave (
    output ex_valid, ex_result, ex_addr, ex_mem_write, ex_mem_to_reg, ex_funct3, ex_dest_reg,
    output dmem_ack, dmem_rdata,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_we, wb_rd, wb_data, bus_err, misalign_trap
  );
endinterface

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - RV32I memory/writeback stage with req/ack data bus and access timeout
// Optional MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of ignoring low address bits.
module mem_writeback #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  mem_writeback_if.master bus
);
  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [29:0] word_q, word_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        bus_err_q, bus_err_d;
  logic        trap_q, trap_d;

  logic [1:0]  a;
  logic        is_byte, is_half, mem_op, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    a         = bus.ex_addr[1:0];
    is_byte   = (bus.ex_funct3 == 3'b000) || (bus.ex_funct3 == 3'b100);
    is_half   = (bus.ex_funct3 == 3'b001) || (bus.ex_funct3 == 3'b101);
    mem_op    = bus.ex_mem_write || bus.ex_mem_to_reg;
`ifdef MISALIGN_TRAP_EN
    misaligned = is_half ? a[0] : (!is_byte && (a != 2'b00));
`else
    misaligned = 1'b0;
`endif
    be_new    = 4'b1111;
    wdata_new = bus.ex_result;
    if (is_byte) begin
      be_new    = 4'b0001 << a;
      wdata_new = {4{bus.ex_result[7:0]}};
    end else if (is_half) begin
      be_new    = a[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{bus.ex_result[15:0]}};
    end
  end

  // Unrecognised funct3 codes fall through to a full-word load.
  always_comb begin
    ld_byte = 8'(bus.dmem_rdata >> {lane_q, 3'b000});
    ld_half = lane_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  // cnt_q holds the ordinal of the current ACCESS cycle, so the request
  // stays up for exactly MEM_TIMEOUT cycles before an unacknowledged abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    lane_d    = lane_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    bus_err_d = 1'b0;
    trap_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!mem_op) begin
            wb_we_d   = (bus.ex_dest_reg != 5'd0);
            wb_rd_d   = bus.ex_dest_reg;
            wb_data_d = bus.ex_result;
          end else if (misaligned) begin
            trap_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = 8'd1;
            word_d  = bus.ex_addr[31:2];
            lane_d  = a;
            we_d    = bus.ex_mem_write;
            be_d    = bus.ex_mem_write ? be_new : 4'b1111;
            wdata_d = wdata_new;
            rd_d    = bus.ex_dest_reg;
            f3_d    = bus.ex_funct3;
          end
        end
      end
      ACCESS: begin
        if (bus.dmem_ack) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          if (!we_q) begin
            wb_we_d   = (rd_q != 5'd0);
            wb_rd_d   = rd_q;
            wb_data_d = ld_data;
          end
        end else if (cnt_q == TIMEOUT) begin
          state_d   = IDLE;
          cnt_d     = 8'd0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      word_q    <= 30'd0;
      lane_q    <= 2'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      f3_q      <= 3'd0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      bus_err_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      lane_q    <= lane_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      bus_err_q <= bus_err_d;
      trap_q    <= trap_d;
    end
  end

  assign bus.ex_ready      = (state_q == IDLE);
  assign bus.dmem_req      = (state_q == ACCESS);
  assign bus.dmem_we       = we_q;
  assign bus.dmem_addr     = {word_q, 2'b00};
  assign bus.dmem_be       = be_q;
  assign bus.dmem_wdata    = wdata_q;
  assign bus.wb_we         = wb_we_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.bus_err       = bus_err_q;
  assign bus.misalign_trap = trap_q;
endmodule
